// File: rtl/rv_wb_pkg.sv
// Shared types and defaults for the register-file write-back slice.
// Load-size encoding, architectural register sizing, zero register.
package rv_wb_pkg;

  localparam int unsigned RV_XLEN = 32;
  localparam int unsigned RV_NREG = 32;
  localparam int unsigned RV_AW   = $clog2(RV_NREG);

  typedef enum logic [1:0] {
    LD_B = 2'b00,
    LD_H = 2'b01,
    LD_W = 2'b10
  } ld_size_e;

  localparam logic [RV_AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/rf_writeback_if.sv
// Result channels into write-back: in-order pipe and MDU.
// Both are valid/ready handshakes; the slave side is rf_writeback.
interface rf_writeback_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);

  logic            pipe_valid;
  logic            pipe_ready;
  logic [AW-1:0]   pipe_rd;
  logic [XLEN-1:0] pipe_data;
  logic            pipe_is_load;
  logic [1:0]      pipe_ld_size;
  logic            pipe_ld_unsigned;
  logic [1:0]      pipe_addr_lo;

  logic            mdu_valid;
  logic            mdu_ready;
  logic [AW-1:0]   mdu_rd;
  logic [XLEN-1:0] mdu_data;

  modport master (
    output pipe_valid, pipe_rd, pipe_data, pipe_is_load,
    output pipe_ld_size, pipe_ld_unsigned, pipe_addr_lo,
    output mdu_valid, mdu_rd, mdu_data,
    input  pipe_ready, mdu_ready
  );

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data, pipe_is_load,
    input  pipe_ld_size, pipe_ld_unsigned, pipe_addr_lo,
    input  mdu_valid, mdu_rd, mdu_data,
    output pipe_ready, mdu_ready
  );

endinterface

// File: rtl/load_align.sv
// Selects the addressed byte/half of a load word and extends it.
// Size 2'b11 falls through to the word path.
module load_align
  import rv_wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  input  logic [1:0]      addr_lo_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;
  logic        is_b;
  logic        is_h;
  logic        sx;

  assign byte_w = data_i[{addr_lo_i, 3'b000} +: 8];
  assign half_w = data_i[{addr_lo_i[1], 4'b0000} +: 16];
  assign is_b   = (size_i == LD_B);
  assign is_h   = (size_i == LD_H);
  assign sx     = ~unsigned_i;

  always_comb begin
    data_o = data_i;
    unique case (1'b1)
      is_b:    data_o = {{(XLEN-8){sx & byte_w[7]}}, byte_w};
      is_h:    data_o = {{(XLEN-16){sx & half_w[15]}}, half_w};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/rf_writeback.sv
// RF write-port arbiter between pipe and MDU, with load alignment
// and a pending-destination scoreboard for decode hazards.
module rf_writeback
  import rv_wb_pkg::*;
#(
  parameter int XLEN         = RV_XLEN,
  parameter int NREG         = RV_NREG,
  parameter int STARVE_LIMIT = 4,
  localparam int AW          = $clog2(NREG)
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  rf_writeback_if.slave   wb,
  input  logic            mdu_issue_i,
  input  logic [AW-1:0]   mdu_issue_rd_i,
  input  logic [AW-1:0]   rs1_i,
  input  logic [AW-1:0]   rs2_i,
  input  logic [AW-1:0]   rd_i,
  output logic            hazard_o,
  output logic            regwrite_o,
  output logic [AW-1:0]   rd_o,
  output logic [XLEN-1:0] wd_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  localparam logic [AW-1:0] RZ    = AW'(REG_ZERO);

  logic [SW-1:0]   starve_q;
  logic [SW-1:0]   starve_d;
  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  logic            pipe_claims;
  logic            mdu_pri;
  logic            pipe_hs;
  logic            mdu_hs;
  logic            pipe_wr;
  logic            mdu_wr;
  logic [XLEN-1:0] ld_word;
  logic [XLEN-1:0] pipe_word;

  load_align #(.XLEN(XLEN)) u_align (
    .data_i     (wb.pipe_data),
    .size_i     (wb.pipe_ld_size),
    .unsigned_i (wb.pipe_ld_unsigned),
    .addr_lo_i  (wb.pipe_addr_lo),
    .data_o     (ld_word)
  );

  assign pipe_word = wb.pipe_is_load ? ld_word : wb.pipe_data;

  assign pipe_claims   = wb.pipe_valid && (wb.pipe_rd != RZ);
  assign mdu_pri       = (starve_q == LIMIT);
  assign wb.mdu_ready  = !pipe_claims || mdu_pri;
  assign wb.pipe_ready = !(mdu_pri && wb.mdu_valid) ||
                         (wb.pipe_rd == RZ);

  assign pipe_hs = wb.pipe_valid && wb.pipe_ready;
  assign mdu_hs  = wb.mdu_valid && wb.mdu_ready;
  assign pipe_wr = pipe_hs && (wb.pipe_rd != RZ);
  assign mdu_wr  = mdu_hs && (wb.mdu_rd != RZ);

  always_comb begin
    starve_d = '0;
    if (wb.mdu_valid && !wb.mdu_ready) begin
      starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + SW'(1);
    end
  end

  // Set after clear so a same-cycle reissue of a retiring rd stays pending
  always_comb begin
    pending_d = pending_q;
    if (mdu_wr) begin
      pending_d[wb.mdu_rd] = 1'b0;
    end
    if (mdu_issue_i && (mdu_issue_rd_i != RZ)) begin
      pending_d[mdu_issue_rd_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  assign hazard_o = ((rs1_i != RZ) && pending_q[rs1_i]) ||
                    ((rs2_i != RZ) && pending_q[rs2_i]) ||
                    ((rd_i  != RZ) && pending_q[rd_i]);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      starve_q  <= '0;
      pending_q <= '0;
    end else begin
      starve_q  <= starve_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      regwrite_o <= 1'b0;
      rd_o       <= '0;
      wd_o       <= '0;
    end else begin
      regwrite_o <= 1'b0;
      unique case (1'b1)
        mdu_wr: begin
          regwrite_o <= 1'b1;
          rd_o       <= wb.mdu_rd;
          wd_o       <= wb.mdu_data;
        end
        pipe_wr: begin
          regwrite_o <= 1'b1;
          rd_o       <= wb.pipe_rd;
          wd_o       <= pipe_word;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback: reset, pipe writes, load alignment,
// MDU starvation priority and the pending-register scoreboard.
module tb_rf_writeback;

  logic        clk;
  logic        rst_n;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rdi;
  logic        hazard;
  logic        regwrite;
  logic [4:0]  rd_o;
  logic [31:0] wd_o;

  int n_chk = 0;
  int n_err = 0;

  rf_writeback_if #(.XLEN(32), .AW(5)) wb ();

  rf_writeback #(.XLEN(32), .NREG(32), .STARVE_LIMIT(4)) dut (
    .clk_i          (clk),
    .reset_ni       (rst_n),
    .wb             (wb),
    .mdu_issue_i    (mdu_issue),
    .mdu_issue_rd_i (mdu_issue_rd),
    .rs1_i          (rs1),
    .rs2_i          (rs2),
    .rd_i           (rdi),
    .hazard_o       (hazard),
    .regwrite_o     (regwrite),
    .rd_o           (rd_o),
    .wd_o           (wd_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shadow pending set, only used to flag illegal re-issue
  logic [31:0] tb_pend;
  logic        tb_clr;
  assign tb_clr = wb.mdu_valid && wb.mdu_ready && (wb.mdu_rd != 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tb_pend <= '0;
    end else begin
      if (mdu_issue && mdu_issue_rd != 0) begin
        assert (!tb_pend[mdu_issue_rd] ||
                (tb_clr && wb.mdu_rd == mdu_issue_rd))
          else $error("illegal issue to pending rd %0d", mdu_issue_rd);
      end
      if (tb_clr) tb_pend[wb.mdu_rd] <= 1'b0;
      if (mdu_issue && mdu_issue_rd != 0)
        tb_pend[mdu_issue_rd] <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic [4:0] rd, input logic [31:0] d,
                      input logic ld, input logic [1:0] sz,
                      input logic uns, input logic [1:0] lo);
    wb.pipe_valid       = 1'b1;
    wb.pipe_rd          = rd;
    wb.pipe_data        = d;
    wb.pipe_is_load     = ld;
    wb.pipe_ld_size     = sz;
    wb.pipe_ld_unsigned = uns;
    wb.pipe_addr_lo     = lo;
    tick();
    wb.pipe_valid = 1'b0;
  endtask

  task automatic load(input string tag, input logic [1:0] sz,
                      input logic uns, input logic [1:0] lo,
                      input logic [31:0] exp);
    pipe(5'd6, 32'h80F0A5C3, 1'b1, sz, uns, lo);
    chk(tag, wd_o, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    mdu_issue = 1'b0;
    mdu_issue_rd = '0;
    rs1 = '0;
    rs2 = '0;
    rdi = '0;
    wb.pipe_valid = 1'b1;
    wb.pipe_rd = 5'd5;
    wb.pipe_data = 32'hAA;
    wb.pipe_is_load = 1'b0;
    wb.pipe_ld_size = 2'b10;
    wb.pipe_ld_unsigned = 1'b0;
    wb.pipe_addr_lo = 2'b00;
    wb.mdu_valid = 1'b0;
    wb.mdu_rd = '0;
    wb.mdu_data = '0;

    repeat (2) tick();
    chk("rst_regwrite", {31'd0, regwrite}, 32'd0);
    chk("rst_rd", {27'd0, rd_o}, 32'd0);
    chk("rst_wd", wd_o, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_idle", {31'd0, regwrite}, 32'd0);
    tick();
    chk("first_we", {31'd0, regwrite}, 32'd1);
    chk("first_rd", {27'd0, rd_o}, 32'd5);
    chk("first_wd", wd_o, 32'hAA);

    pipe(5'd3, 32'h12345678, 1'b0, 2'b00, 1'b0, 2'd1);
    chk("alu_we", {31'd0, regwrite}, 32'd1);
    chk("alu_rd", {27'd0, rd_o}, 32'd3);
    chk("alu_wd", wd_o, 32'h12345678);

    wb.pipe_valid = 1'b1;
    wb.pipe_rd = 5'd0;
    wb.pipe_data = 32'hDEAD;
    #1;
    chk("r0_ready", {31'd0, wb.pipe_ready}, 32'd1);
    tick();
    wb.pipe_valid = 1'b0;
    chk("r0_we", {31'd0, regwrite}, 32'd0);
    chk("r0_rd_hold", {27'd0, rd_o}, 32'd3);
    chk("r0_wd_hold", wd_o, 32'h12345678);

    load("lb_lo2", 2'b00, 1'b0, 2'd2, 32'hFFFFFFF0);
    load("lhu_lo2", 2'b01, 1'b1, 2'd2, 32'h000080F0);
    load("lh_lo0", 2'b01, 1'b0, 2'd0, 32'hFFFFA5C3);
    load("lbu_lo3", 2'b00, 1'b1, 2'd3, 32'h00000080);
    load("lb_lo0", 2'b00, 1'b0, 2'd0, 32'hFFFFFFC3);
    load("lh_lo3", 2'b01, 1'b0, 2'd3, 32'hFFFF80F0);
    load("lw", 2'b10, 1'b0, 2'd1, 32'h80F0A5C3);
    load("lsz11", 2'b11, 1'b1, 2'd2, 32'h80F0A5C3);

    wb.pipe_valid = 1'b1;
    wb.pipe_rd = 5'd10;
    wb.pipe_data = 32'h1010;
    wb.pipe_is_load = 1'b0;
    wb.mdu_valid = 1'b1;
    wb.mdu_rd = 5'd7;
    wb.mdu_data = 32'h777;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("starve_mdu_rdy", {31'd0, wb.mdu_ready}, 32'd0);
      tick();
      chk("starve_pipe_rd", {27'd0, rd_o}, 32'd10);
    end
    #1;
    chk("pri_mdu_rdy", {31'd0, wb.mdu_ready}, 32'd1);
    chk("pri_pipe_rdy", {31'd0, wb.pipe_ready}, 32'd0);
    tick();
    wb.mdu_valid = 1'b0;
    chk("pri_rd", {27'd0, rd_o}, 32'd7);
    chk("pri_wd", wd_o, 32'h777);
    #1;
    chk("pri_cleared", {31'd0, wb.mdu_ready}, 32'd0);
    wb.pipe_valid = 1'b0;

    mdu_issue = 1'b1;
    mdu_issue_rd = 5'd9;
    #1;
    chk("haz_issue_cycle", {31'd0, hazard}, 32'd0);
    tick();
    mdu_issue = 1'b0;
    rs1 = 5'd9;
    #1;
    chk("haz_rs1", {31'd0, hazard}, 32'd1);
    tick();
    chk("haz_rs1_hold", {31'd0, hazard}, 32'd1);
    wb.mdu_valid = 1'b1;
    wb.mdu_rd = 5'd9;
    wb.mdu_data = 32'h99;
    #1;
    chk("haz_grant_cycle", {31'd0, hazard}, 32'd1);
    tick();
    wb.mdu_valid = 1'b0;
    chk("haz_wr_rd", {27'd0, rd_o}, 32'd9);
    chk("haz_wr_wd", wd_o, 32'h99);
    chk("haz_cleared", {31'd0, hazard}, 32'd0);

    rs1 = 5'd0;
    mdu_issue = 1'b1;
    mdu_issue_rd = 5'd0;
    tick();
    mdu_issue = 1'b0;
    chk("haz_r0_issue", {31'd0, hazard}, 32'd0);

    mdu_issue = 1'b1;
    mdu_issue_rd = 5'd4;
    tick();
    wb.mdu_valid = 1'b1;
    wb.mdu_rd = 5'd4;
    wb.mdu_data = 32'h44;
    tick();
    mdu_issue = 1'b0;
    wb.mdu_valid = 1'b0;
    rs2 = 5'd4;
    #1;
    chk("same_cyc_we", {31'd0, regwrite}, 32'd1);
    chk("same_cyc_haz", {31'd0, hazard}, 32'd1);
    tick();
    chk("same_cyc_hold", {31'd0, hazard}, 32'd1);
    wb.mdu_valid = 1'b1;
    tick();
    wb.mdu_valid = 1'b0;
    chk("rs2_cleared", {31'd0, hazard}, 32'd0);
    rs2 = 5'd0;

    mdu_issue = 1'b1;
    mdu_issue_rd = 5'd12;
    tick();
    mdu_issue = 1'b0;
    rdi = 5'd12;
    #1;
    chk("haz_rd", {31'd0, hazard}, 32'd1);
    wb.pipe_valid = 1'b1;
    wb.pipe_rd = 5'd2;
    wb.pipe_data = 32'h22;
    tick();
    chk("pre_rst_we", {31'd0, regwrite}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_haz", {31'd0, hazard}, 32'd0);
    chk("mid_rst_we", {31'd0, regwrite}, 32'd0);
    chk("mid_rst_wd", wd_o, 32'd0);
    wb.pipe_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("after_rst_haz", {31'd0, hazard}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
